regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 4-entry x 16-bit register file between two writeback requesters: req0 (ALU) and req1 (load unit).
- Arbitration is round-robin with a valid/ready handshake.
- Drives a registered, one-cycle write pulse into the register file.
- Keeps a per-register pending-write scoreboard so the issue stage can detect read-after-write hazards on both read ports.

Parameters:
- DATA_W, 16, register data width
- ADDR_W, 2, register address width (number of registers = 2**ADDR_W)
- CNT_W, 2, pending-write counter width per register (saturates at 2**CNT_W-1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- Req0Valid  in  1  requester 0 has writeback data
- Req0Addr  in  ADDR_W  requester 0 destination register
- Req0Data  in  DATA_W  requester 0 data
- Req0Ready  out  1  requester 0 accepted this cycle
- Req1Valid / Req1Addr / Req1Data / Req1Ready  same as req0, for requester 1
- IssueValid  in  1  issue stage reserves a destination register
- IssueAddr  in  ADDR_W  register being reserved
- IssueReady  out  1  reservation accepted (counter not saturated)
- RdAddrA, RdAddrB  in  ADDR_W  read addresses presented to the register file
- HazardA, HazardB  out  1  read port addresses a register with an outstanding write
- Write  out  1  register file write enable
- DestAddr  out  ADDR_W  register file write address
- DestData  out  DATA_W  register file write data
- BypA, BypB  out  1  bypass hit on read port A / B (tied 0 without the optional feature)
- BypData  out  DATA_W  bypass data (tied 0 without the optional feature)

Behaviour:
- Reset (asynchronous, any time): Write=0, DestAddr=0, DestData=0, all pending counters=0, round-robin pointer favours req0. Req/Issue ready outputs follow combinationally from the reset state. A writeback accepted in the same cycle reset asserts is discarded.
- Arbitration (combinational):
  - Exactly one Ready is asserted per cycle, and only to a valid requester.
  - If both are valid, the requester not granted last is chosen.
  - If only one is valid, it is granted regardless of the pointer.
  - The pointer updates only on an actual grant.
  - Ready never depends on the other requester's Ready.
- Output stage:
  - An accepted handshake at edge N gives Write=1 with DestAddr/DestData of the winner during cycle N+1.
  - Write=0 in any cycle following no grant.
  - Back-to-back grants give continuous Write=1.
  - Latency from request to register file commit is 2 edges.
- Scoreboard, one counter per register:
  - +1 at an edge where IssueValid&IssueReady targets that register.
  - -1 at an edge where Write=1 targets that register.
  - A simultaneous +1 and -1 on the same register leaves the counter unchanged.
  - IssueReady=0 when the counter of IssueAddr is saturated (3); it is 1 otherwise, including during a simultaneous commit.
  - A commit to a register with counter 0 is a protocol error: the counter stays 0 (no underflow).
- Hazards: HazardA = (counter[RdAddrA]!=0); HazardB likewise. Purely combinational on the current counters.
- Writebacks are not checked against reservations; the requesters own that ordering.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- With the macro defined:
  - BypA = Write && (DestAddr==RdAddrA); BypB likewise; BypData = DestData.
  - HazardA is suppressed when BypA=1, counter[RdAddrA]==1, and no reservation for RdAddrA is being accepted this cycle. HazardB likewise.
  - This lets the consumer read the value in the commit cycle.
- Without the macro: BypA=BypB=0, BypData=0, and hazards follow the plain counter rule.

Test Plan:
- Reset mid-stream: req0 valid with Addr=1 and Data=0x1234; assert rst before the next edge -> Write stays 0 and all counters read 0 (HazardA=0 for every RdAddrA).
- Single requester: req1 presents Addr=2, Data=0xBEEF for one cycle -> Req1Ready=1 that cycle; next cycle Write=1, DestAddr=2, DestData=0xBEEF; following cycle Write=0.
- Contention: both valid continuously, req0 Data=0x000A and req1 Data=0x000B (Addr=3) -> grants alternate 0,1,0,1 and DestData alternates 0x000A/0x000B with Write held high.
- Scoreboard:
  - Issue Addr=0 three times -> HazardA=1 for RdAddrA=0 and IssueReady=0 for Addr=0.
  - Then commit one writeback to 0 -> IssueReady returns to 1 and HazardA stays 1.
  - After three commits -> HazardA=0.
- Simultaneous issue and commit on Addr=1 with counter=1 -> counter stays 1 and HazardA stays 1.
- Bypass (macro defined): counter[2]=1, writeback Addr=2 with Data=0x5A5A, RdAddrA=2 -> in the Write cycle BypA=1, BypData=0x5A5A, HazardA=0. Same stimulus without the macro -> BypA=0 and HazardA=1.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback, issue and read-port signals of the register file write arbiter
// Port summary (master = requesters/issue/read side, slave = arbiter):
//   Req0*/Req1*   : writeback handshakes (Valid/Addr/Data in, Ready out)
//   Issue*        : destination reservation handshake
//   RdAddrA/B     : read addresses, HazardA/B hazard flags back
//   Write/DestAddr/DestData : register file write port
//   BypA/BypB/BypData       : commit-cycle bypass (zero unless REGFILE_WB_BYPASS_EN)
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2
);
    logic              Req0Valid;
    logic [ADDR_W-1:0] Req0Addr;
    logic [DATA_W-1:0] Req0Data;
    logic              Req0Ready;
    logic              Req1Valid;
    logic [ADDR_W-1:0] Req1Addr;
    logic [DATA_W-1:0] Req1Data;
    logic              Req1Ready;
    logic              IssueValid;
    logic [ADDR_W-1:0] IssueAddr;
    logic              IssueReady;
    logic [ADDR_W-1:0] RdAddrA;
    logic [ADDR_W-1:0] RdAddrB;
    logic              HazardA;
    logic              HazardB;
    logic              Write;
    logic [ADDR_W-1:0] DestAddr;
    logic [DATA_W-1:0] DestData;
    logic              BypA;
    logic              BypB;
    logic [DATA_W-1:0] BypData;
    modport master (
        output Req0Valid, Req0Addr, Req0Data, Req1Valid, Req1Addr, Req1Data,
               IssueValid, IssueAddr, RdAddrA, RdAddrB,
        input  Req0Ready, Req1Ready, IssueReady, HazardA, HazardB,
               Write, DestAddr, DestData, BypA, BypB, BypData
    );
    modport slave (
        input  Req0Valid, Req0Addr, Req0Data, Req1Valid, Req1Addr, Req1Data,
               IssueValid, IssueAddr, RdAddrA, RdAddrB,
        output Req0Ready, Req1Ready, IssueReady, HazardA, HazardB,
               Write, DestAddr, DestData, BypA, BypB, BypData
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter for the register file write port with pending-write scoreboard
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : regfile_wb_arbiter_if.slave (writeback requests, issue reservations,
//         read-port hazard flags, registered write port, bypass)
// Optional feature: define REGFILE_WB_BYPASS_EN to drive the bypass outputs and
// let a read in the commit cycle skip the hazard on the final pending write.
module regfile_wb_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 2
) (
    input logic              clk,
    input logic              rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int NREG = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic                   ptr;
    logic                   gnt0;
    logic                   gnt1;
    logic                   issue_take;
    logic                   wr;
    logic [ADDR_W-1:0]      dest_addr;
    logic [DATA_W-1:0]      dest_data;
    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic [NREG-1:0]        inc;
    logic [NREG-1:0]        dec;
    logic                   raw_a;
    logic                   raw_b;

    // ptr=1 favours req1; each grant is decided from valids and ptr only
    assign gnt0 = bus.Req0Valid && (!bus.Req1Valid || !ptr);
    assign gnt1 = bus.Req1Valid && (!bus.Req0Valid || ptr);
    assign bus.Req0Ready = gnt0;
    assign bus.Req1Ready = gnt1;

    assign bus.IssueReady = cnt[bus.IssueAddr] != CNT_MAX;
    assign issue_take     = bus.IssueValid && bus.IssueReady;

    assign bus.Write    = wr;
    assign bus.DestAddr = dest_addr;
    assign bus.DestData = dest_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= 1'b0;
            wr        <= 1'b0;
            dest_addr <= '0;
            dest_data <= '0;
        end else begin
            wr <= gnt0 || gnt1;
            if (gnt0 || gnt1) begin
                ptr       <= gnt0;
                dest_addr <= gnt1 ? bus.Req1Addr : bus.Req0Addr;
                dest_data <= gnt1 ? bus.Req1Data : bus.Req0Data;
            end
        end
    end

    // A commit to an idle register is ignored so the counter cannot underflow
    always_comb begin
        inc = '0;
        dec = '0;
        for (int i = 0; i < NREG; i++) begin
            inc[i] = issue_take && bus.IssueAddr == ADDR_W'(i);
            dec[i] = wr && dest_addr == ADDR_W'(i) && cnt[i] != '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < NREG; i++)
                if (inc[i] != dec[i])
                    cnt[i] <= inc[i] ? cnt[i] + 1'b1 : cnt[i] - 1'b1;
        end
    end

    assign raw_a = cnt[bus.RdAddrA] != '0;
    assign raw_b = cnt[bus.RdAddrB] != '0;

`ifdef REGFILE_WB_BYPASS_EN
    assign bus.BypA    = wr && dest_addr == bus.RdAddrA;
    assign bus.BypB    = wr && dest_addr == bus.RdAddrB;
    assign bus.BypData = dest_data;
    // The commit in flight retires the last pending write unless a new
    // reservation for the same register lands this cycle
    assign bus.HazardA = raw_a && !(bus.BypA && cnt[bus.RdAddrA] == CNT_ONE &&
                                    !(issue_take && bus.IssueAddr == bus.RdAddrA));
    assign bus.HazardB = raw_b && !(bus.BypB && cnt[bus.RdAddrB] == CNT_ONE &&
                                    !(issue_take && bus.IssueAddr == bus.RdAddrB));
`else
    assign bus.BypA    = 1'b0;
    assign bus.BypB    = 1'b0;
    assign bus.BypData = '0;
    assign bus.HazardA = raw_a;
    assign bus.HazardB = raw_b;
`endif

endmodule
